// File: rtl/algo_1r2m_m30_client_pkg.sv
// Shared types and constants for the 1R2M m30 requester-side client.
package algo_1r2m_m30_client_pkg;

  typedef enum logic [1:0] {
    StInit  = 2'd0,
    StRun   = 2'd1,
    StDrain = 2'd2
  } state_e;

  // Lane 0 is always queued ahead of lane 1 when both write in one cycle.
  localparam int unsigned LaneFirst  = 0;
  localparam int unsigned LaneSecond = 1;

  // Upstream is only accepted when a full dual-lane push is guaranteed to fit.
  localparam int unsigned HqMinFree = 2;

endpackage

// File: rtl/algo_1r2m_m30_client_fifo.sv
// Pointer-wrap FIFO with synchronous clear and optional second push lane.
module algo_1r2m_m30_client_fifo #(
  parameter int unsigned Width    = 32,
  parameter int unsigned Depth    = 16,
  parameter int unsigned AddrW    = 4,
  parameter bit          DualPush = 1'b0
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             clr_i,
  input  logic             push0_i,
  input  logic [Width-1:0] din0_i,
  input  logic             push1_i,
  input  logic [Width-1:0] din1_i,
  input  logic             pop_i,
  output logic [Width-1:0] dout_o,
  output logic             empty_o,
  output logic             full_o,
  output logic [AddrW:0]   count_o
);

  logic [Width-1:0] mem_q [Depth];
  logic [Width-1:0] mem_d [Depth];
  logic [AddrW:0]   wptr_q, wptr_d;
  logic [AddrW:0]   rptr_q, rptr_d;
  logic [AddrW-1:0] wr_idx0, wr_idx1;
  logic             push1;

  // The second lane only ever lands behind the first one.
  assign push1   = DualPush & push0_i & push1_i;
  assign wr_idx0 = wptr_q[AddrW-1:0];
  assign wr_idx1 = wr_idx0 + AddrW'(1);

  always_comb begin
    mem_d  = mem_q;
    wptr_d = wptr_q + (AddrW+1)'(push0_i) + (AddrW+1)'(push1);
    rptr_d = rptr_q + (AddrW+1)'(pop_i);
    if (push0_i) mem_d[wr_idx0] = din0_i;
    if (push1)   mem_d[wr_idx1] = din1_i;
    if (clr_i) begin
      wptr_d = '0;
      rptr_d = '0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
    end
  end

  always_ff @(posedge clk_i) begin
    mem_q <= mem_d;
  end

  assign count_o = wptr_q - rptr_q;
  assign empty_o = (count_o == '0);
  assign full_o  = (count_o == (AddrW+1)'(Depth));
  assign dout_o  = mem_q[rptr_q[AddrW-1:0]];

endmodule

// File: rtl/algo_1r2m_m30_client.sv
// Requester-side client of the m30 1R2M allocating buffer: writes, replays handles, returns data.
// Optional error counters enabled with ALGO_1R2M_M30_CLIENT_ERRCNT_EN.
module algo_1r2m_m30_client
  import algo_1r2m_m30_client_pkg::*;
#(
  parameter int unsigned WIDTH    = 32,
  parameter int unsigned BITADDR  = 13,
  parameter int unsigned NUMWRPT  = 2,
  parameter int unsigned BITPADR  = 17,
  parameter int unsigned RD_DELAY = 4,
  parameter int unsigned HQ_DEPTH = 16,
  parameter int unsigned BITHQ    = 4,
  parameter int unsigned OB_DEPTH = 8,
  parameter int unsigned BITOB    = 3
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       ready,
  input  logic                       flush,
  input  logic [NUMWRPT-1:0]         in_vld,
  input  logic [NUMWRPT*WIDTH-1:0]   in_din,
  output logic                       in_rdy,
  output logic [NUMWRPT-1:0]         ma_write,
  output logic [NUMWRPT*WIDTH-1:0]   ma_din,
  input  logic [NUMWRPT*BITADDR-1:0] ma_adr,
  input  logic [NUMWRPT-1:0]         ma_bp,
  output logic                       read,
  output logic                       rd_deq,
  output logic [BITADDR-1:0]         rd_adr,
  input  logic                       rd_vld,
  input  logic [WIDTH-1:0]           rd_dout,
  input  logic                       rd_serr,
  input  logic                       rd_derr,
  input  logic [BITPADR-1:0]         rd_padr,
  output logic                       out_vld,
  output logic [WIDTH-1:0]           out_dout,
  input  logic                       out_rdy,
`ifdef ALGO_1R2M_M30_CLIENT_ERRCNT_EN
  output logic [15:0]                serr_cnt,
  output logic [15:0]                derr_cnt,
  output logic [BITPADR-1:0]         last_err_padr,
`endif
  output logic                       busy
);

  // Drain issues reads without credit, so in-flight can exceed OB_DEPTH.
  localparam int unsigned InflW = $clog2(OB_DEPTH + HQ_DEPTH + 1);
  localparam logic [BITHQ:0] HqLimit   = (BITHQ+1)'(HQ_DEPTH - HqMinFree);
  localparam logic [InflW:0] CreditMax = (InflW+1)'(OB_DEPTH);

  state_e           state_q, state_d;
  logic [InflW-1:0] inflight_q, inflight_d;
  logic             ovf_q, ovf_d;

  logic               hq_push0, hq_push1, hq_pop, hq_empty, hq_full;
  logic [BITADDR-1:0] hq_din0, hq_din1, hq_head;
  logic [BITHQ:0]     hq_count;
  logic               ob_push, ob_pop, ob_clr, ob_empty, ob_full;
  logic [BITOB:0]     ob_count;
  logic               run, drain, credit_ok, issue, ret_ok;

  always_comb begin
    run       = (state_q == StRun);
    drain     = (state_q == StDrain);
    in_rdy    = run & ready & ~|ma_bp & (hq_count <= HqLimit);
    ma_write  = in_vld & {NUMWRPT{in_rdy}};
    ma_din    = in_din;
    credit_ok = ({1'b0, inflight_q} + (InflW+1)'(ob_count)) < CreditMax;
    issue     = ~hq_empty & ready & ((run & credit_ok) | drain);
    read      = issue;
    rd_deq    = issue;
    rd_adr    = hq_head;
    hq_pop    = issue;

    hq_push0 = |ma_write;
    hq_push1 = &ma_write;
    hq_din0  = ma_write[LaneFirst] ? ma_adr[LaneFirst*BITADDR +: BITADDR]
                                   : ma_adr[LaneSecond*BITADDR +: BITADDR];
    hq_din1  = ma_adr[LaneSecond*BITADDR +: BITADDR];

    ob_push = rd_vld & run & ~ob_full;
    ovf_d   = ovf_q | (rd_vld & run & ob_full);
    ob_clr  = run & flush;
    out_vld = run & ~ob_empty;
    ob_pop  = out_vld & out_rdy;

    ret_ok     = rd_vld & (inflight_q != '0);
    inflight_d = inflight_q;
    unique case ({issue, ret_ok})
      2'b10:   inflight_d = inflight_q + InflW'(1);
      2'b01:   inflight_d = inflight_q - InflW'(1);
      default: inflight_d = inflight_q;
    endcase

    state_d = state_q;
    unique case (state_q)
      StInit:  if (ready) state_d = StRun;
      StRun:   if (flush) state_d = StDrain;
      StDrain: if (hq_empty && (inflight_q == '0)) state_d = StInit;
      default: state_d = StInit;
    endcase

    busy = ~run | ~hq_empty | (inflight_q != '0) | ~ob_empty;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StInit;
      inflight_q <= '0;
      ovf_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      inflight_q <= inflight_d;
      ovf_q      <= ovf_d;
    end
  end

  algo_1r2m_m30_client_fifo #(
    .Width   (BITADDR),
    .Depth   (HQ_DEPTH),
    .AddrW   (BITHQ),
    .DualPush(1'b1)
  ) u_hq (
    .clk_i  (clk),
    .rst_i  (rst),
    .clr_i  (1'b0),
    .push0_i(hq_push0),
    .din0_i (hq_din0),
    .push1_i(hq_push1),
    .din1_i (hq_din1),
    .pop_i  (hq_pop),
    .dout_o (hq_head),
    .empty_o(hq_empty),
    .full_o (hq_full),
    .count_o(hq_count)
  );

  algo_1r2m_m30_client_fifo #(
    .Width   (WIDTH),
    .Depth   (OB_DEPTH),
    .AddrW   (BITOB),
    .DualPush(1'b0)
  ) u_ob (
    .clk_i  (clk),
    .rst_i  (rst),
    .clr_i  (ob_clr),
    .push0_i(ob_push),
    .din0_i (rd_dout),
    .push1_i(1'b0),
    .din1_i ('0),
    .pop_i  (ob_pop),
    .dout_o (out_dout),
    .empty_o(ob_empty),
    .full_o (ob_full),
    .count_o(ob_count)
  );

`ifdef ALGO_1R2M_M30_CLIENT_ERRCNT_EN
  logic [15:0]        serr_cnt_q, serr_cnt_d, derr_cnt_q, derr_cnt_d;
  logic [BITPADR-1:0] last_err_padr_q, last_err_padr_d;

  always_comb begin
    serr_cnt_d      = serr_cnt_q;
    derr_cnt_d      = derr_cnt_q;
    last_err_padr_d = last_err_padr_q;
    if (rd_vld && rd_serr && (serr_cnt_q != 16'hFFFF)) serr_cnt_d = serr_cnt_q + 16'd1;
    if (rd_vld && rd_derr && (derr_cnt_q != 16'hFFFF)) derr_cnt_d = derr_cnt_q + 16'd1;
    if (rd_vld && (rd_serr || rd_derr)) last_err_padr_d = rd_padr;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      serr_cnt_q      <= '0;
      derr_cnt_q      <= '0;
      last_err_padr_q <= '0;
    end else begin
      serr_cnt_q      <= serr_cnt_d;
      derr_cnt_q      <= derr_cnt_d;
      last_err_padr_q <= last_err_padr_d;
    end
  end

  assign serr_cnt      = serr_cnt_q;
  assign derr_cnt      = derr_cnt_q;
  assign last_err_padr = last_err_padr_q;

  logic unused_sigs;
  assign unused_sigs = hq_full;
`else
  logic unused_sigs;
  assign unused_sigs = ^{hq_full, rd_serr, rd_derr, rd_padr};
`endif

endmodule

// File: tb/tb_algo_1r2m_m30_client.sv
// Scoreboard bench for algo_1r2m_m30_client with a fixed-latency buffer model.
module tb_algo_1r2m_m30_client;

  localparam int unsigned WIDTH    = 32;
  localparam int unsigned BITADDR  = 13;
  localparam int unsigned NUMWRPT  = 2;
  localparam int unsigned BITPADR  = 17;
  localparam int unsigned RD_DELAY = 4;

  logic                       clk, rst, ready, flush;
  logic [NUMWRPT-1:0]         in_vld;
  logic [NUMWRPT*WIDTH-1:0]   in_din;
  logic                       in_rdy;
  logic [NUMWRPT-1:0]         ma_write;
  logic [NUMWRPT*WIDTH-1:0]   ma_din;
  logic [NUMWRPT*BITADDR-1:0] ma_adr;
  logic [NUMWRPT-1:0]         ma_bp;
  logic                       read, rd_deq;
  logic [BITADDR-1:0]         rd_adr;
  logic                       rd_vld;
  logic [WIDTH-1:0]           rd_dout;
  logic                       rd_serr, rd_derr;
  logic [BITPADR-1:0]         rd_padr;
  logic                       out_vld;
  logic [WIDTH-1:0]           out_dout;
  logic                       out_rdy;
  logic                       busy;
`ifdef ALGO_1R2M_M30_CLIENT_ERRCNT_EN
  logic [15:0]                serr_cnt, derr_cnt;
  logic [BITPADR-1:0]         last_err_padr;
`endif

  algo_1r2m_m30_client dut (
    .clk          (clk),
    .rst          (rst),
    .ready        (ready),
    .flush        (flush),
    .in_vld       (in_vld),
    .in_din       (in_din),
    .in_rdy       (in_rdy),
    .ma_write     (ma_write),
    .ma_din       (ma_din),
    .ma_adr       (ma_adr),
    .ma_bp        (ma_bp),
    .read         (read),
    .rd_deq       (rd_deq),
    .rd_adr       (rd_adr),
    .rd_vld       (rd_vld),
    .rd_dout      (rd_dout),
    .rd_serr      (rd_serr),
    .rd_derr      (rd_derr),
    .rd_padr      (rd_padr),
    .out_vld      (out_vld),
    .out_dout     (out_dout),
    .out_rdy      (out_rdy),
`ifdef ALGO_1R2M_M30_CLIENT_ERRCNT_EN
    .serr_cnt     (serr_cnt),
    .derr_cnt     (derr_cnt),
    .last_err_padr(last_err_padr),
`endif
    .busy         (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int read_cnt = 0;
  int drain_out_cnt = 0;
  bit in_drain = 1'b0;

  logic [BITADDR-1:0] exp_adr_q [$];
  logic [WIDTH-1:0]   exp_data_q [$];
  logic [1:0]         err_tag_q [$];
  logic [WIDTH-1:0]   mem [0:8191];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitor: every read and every downstream transfer is checked against the scoreboard.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (read) begin
          read_cnt++;
          check("rd_deq", 64'(rd_deq), 64'd1);
          if (exp_adr_q.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL unexpected_read: got adr %0h expected no read", rd_adr);
          end else begin
            check("rd_adr", 64'(rd_adr), 64'(exp_adr_q.pop_front()));
          end
        end
        if (out_vld && in_drain) drain_out_cnt++;
        if (out_vld && out_rdy) begin
          if (exp_data_q.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL unexpected_out: got %0h expected no output", out_dout);
          end else begin
            check("out_dout", 64'(out_dout), 64'(exp_data_q.pop_front()));
          end
        end
      end
    end
  end

  // Buffer read-side model: data returns RD_DELAY cycles after the read cycle.
  logic               pipe_v [RD_DELAY];
  logic [BITADDR-1:0] pipe_a [RD_DELAY];
  logic [1:0]         pipe_e [RD_DELAY];
  initial begin
    logic               cv;
    logic [BITADDR-1:0] ca;
    logic [1:0]         ce;
    for (int i = 0; i < RD_DELAY; i++) begin
      pipe_v[i] = 1'b0;
      pipe_a[i] = '0;
      pipe_e[i] = '0;
    end
    rd_vld = 1'b0; rd_dout = '0; rd_serr = 1'b0; rd_derr = 1'b0; rd_padr = '0;
    forever begin
      @(negedge clk);
      cv = read & ~rst;
      ca = rd_adr;
      ce = 2'b00;
      if (cv && err_tag_q.size() > 0) ce = err_tag_q.pop_front();
      @(posedge clk);
      #1;
      for (int i = RD_DELAY - 1; i > 0; i--) begin
        pipe_v[i] = pipe_v[i-1];
        pipe_a[i] = pipe_a[i-1];
        pipe_e[i] = pipe_e[i-1];
      end
      pipe_v[0] = cv;
      pipe_a[0] = ca;
      pipe_e[0] = ce;
      rd_vld  = pipe_v[RD_DELAY-1];
      rd_dout = mem[pipe_a[RD_DELAY-1]];
      rd_serr = pipe_v[RD_DELAY-1] & pipe_e[RD_DELAY-1][0];
      rd_derr = pipe_v[RD_DELAY-1] & pipe_e[RD_DELAY-1][1];
      rd_padr = (rd_serr | rd_derr) ? 17'h1ABCD : 17'h0;
    end
  end

  task automatic wr(input logic [1:0] vld, input logic [WIDTH-1:0] d0, input logic [WIDTH-1:0] d1,
                    input logic [BITADDR-1:0] a0, input logic [BITADDR-1:0] a1);
    bit done;
    done   = 1'b0;
    in_vld = vld;
    in_din = {d1, d0};
    ma_adr = {a1, a0};
    for (int i = 0; i < 200 && !done; i++) begin
      @(negedge clk);
      if (in_rdy) begin
        check("ma_write", 64'(ma_write), 64'(vld));
        check("ma_din", 64'(ma_din), {d1, d0});
        if (vld[0]) begin mem[a0] = d0; exp_adr_q.push_back(a0); exp_data_q.push_back(d0); end
        if (vld[1]) begin mem[a1] = d1; exp_adr_q.push_back(a1); exp_data_q.push_back(d1); end
        done = 1'b1;
      end
      tick();
    end
    in_vld = '0;
    if (!done) begin
      n_tests++;
      n_fail++;
      $display("FAIL write_timeout: in_rdy stayed 0, required 1 within 200 cycles");
    end
  endtask

  task automatic wait_idle(input string name);
    bit idle;
    idle = 1'b0;
    for (int i = 0; i < 400 && !idle; i++) begin
      @(negedge clk);
      if (!busy) idle = 1'b1;
    end
    check(name, 64'(busy), 64'd0);
    check({name, "_adr_left"}, 64'(exp_adr_q.size()), 64'd0);
    check({name, "_data_left"}, 64'(exp_data_q.size()), 64'd0);
    tick();
  endtask

  initial begin
    int rc0;
    rst = 1'b1; ready = 1'b0; flush = 1'b0; in_vld = '0; in_din = '0; ma_adr = '0;
    ma_bp = '0; out_rdy = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Held in INIT while the buffer is not ready.
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("init_in_rdy", 64'(in_rdy), 64'd0);
      check("init_busy", 64'(busy), 64'd1);
    end
    check("init_out_vld", 64'(out_vld), 64'd0);
    check("init_read", 64'(read), 64'd0);
    check("init_ma_write", 64'(ma_write), 64'd0);
    tick();
    ready = 1'b1;
    @(negedge clk);
    check("ready_same_cycle_in_rdy", 64'(in_rdy), 64'd0);
    @(negedge clk);
    check("run_in_rdy", 64'(in_rdy), 64'd1);
    tick();

    // Dual-lane write, lane 0 ahead of lane 1.
    wr(2'b11, 32'hA, 32'hB, 13'h10, 13'h20);
    wait_idle("basic_idle");

    // Stalled consumer: credits cap outstanding reads at OB_DEPTH.
    out_rdy = 1'b0;
    rc0 = read_cnt;
    for (int i = 0; i < 10; i++)
      wr(2'b11, 32'h1000 + 32'(2*i), 32'h1001 + 32'(2*i), 13'(13'h100 + 2*i), 13'(13'h101 + 2*i));
    repeat (20) tick();
    check("stall_reads", 64'(read_cnt - rc0), 64'd8);
    for (int i = 0; i < 3; i++) wr(2'b10, 32'h0, 32'h2000 + 32'(i), 13'h0, 13'(13'h200 + i));

    // HQ holds 15: backpressure, then lack of two free slots, keep upstream blocked.
    in_vld = 2'b11; in_din = {32'h3001, 32'h3000}; ma_adr = {13'h301, 13'h300}; ma_bp = 2'b01;
    @(negedge clk);
    check("bp_in_rdy", 64'(in_rdy), 64'd0);
    check("bp_ma_write", 64'(ma_write), 64'd0);
    tick();
    ma_bp = 2'b00;
    @(negedge clk);
    check("hq15_in_rdy", 64'(in_rdy), 64'd0);
    check("hq15_stall_reads", 64'(read_cnt - rc0), 64'd8);
    tick();
    in_vld = 2'b00;
    out_rdy = 1'b1;
    wait_idle("stall_idle");

    // Flush with handles queued and reads in flight.
    out_rdy = 1'b0;
    for (int i = 0; i < 7; i++)
      wr(2'b11, 32'h4000 + 32'(2*i), 32'h4001 + 32'(2*i), 13'(13'h400 + 2*i), 13'(13'h401 + 2*i));
    repeat (30) tick();
    out_rdy = 1'b1;
    tick();
    tick();
    out_rdy = 1'b0;
    flush = 1'b1;
    exp_data_q.delete();
    tick();
    flush = 1'b0;
    in_drain = 1'b1;
    @(negedge clk);
    check("drain_in_rdy", 64'(in_rdy), 64'd0);
    check("drain_busy", 64'(busy), 64'd1);
    tick();
    wait_idle("drain_idle");
    in_drain = 1'b0;
    check("drain_out_vld", 64'(drain_out_cnt), 64'd0);

    // Normal operation after the flush.
    out_rdy = 1'b1;
    wr(2'b11, 32'hC, 32'hD, 13'h30, 13'h40);
    wr(2'b01, 32'hE, 32'h0, 13'h50, 13'h0);
    wait_idle("resume_idle");

`ifdef ALGO_1R2M_M30_CLIENT_ERRCNT_EN
    err_tag_q.push_back(2'b01);
    err_tag_q.push_back(2'b01);
    err_tag_q.push_back(2'b01);
    err_tag_q.push_back(2'b10);
    wr(2'b11, 32'h5000, 32'h5001, 13'h500, 13'h501);
    wr(2'b11, 32'h5002, 32'h5003, 13'h502, 13'h503);
    wait_idle("err_idle");
    check("serr_cnt", 64'(serr_cnt), 64'd3);
    check("derr_cnt", 64'(derr_cnt), 64'd1);
    check("last_err_padr", 64'(last_err_padr), 64'h1ABCD);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
